// File: rtl/mvm_pkg.sv
// mvm_pkg: parameters and types shared by the UART matrix-vector system.
//   R, C, W_K, W_X    : matrix/vector geometry and element widths
//   BITS_PER_WORD     : data bits per UART frame
//   CLOCKS_PER_PULSE  : clk cycles per UART bit (50 MHz / 921600)
//   W_BUS_KX          : packed K/X operand bus width
//   N_WORDS_KX        : UART bytes per operand packet
//   rx_state_e        : UART receiver FSM states
package mvm_pkg;

   localparam int R                = 2;
   localparam int C                = 2;
   localparam int W_K              = 4;
   localparam int W_X              = 4;
   localparam int BITS_PER_WORD    = 8;
   localparam int CLOCKS_PER_PULSE = 54;

   localparam int W_BUS_KX   = R*C*W_K + C*W_X;
   localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

endpackage

// File: rtl/uart_rx_packer_if.sv
// uart_rx_packer_if: valid/ready packet bus from the UART packer to the MVM core.
//   m_data  : packed packet, first received byte in the LSB byte
//   m_valid : m_data holds a complete packet
//   m_ready : consumer accepts on a cycle where m_valid && m_ready
// master = packer side, slave = consumer side.
interface uart_rx_packer_if #(
   parameter int W_BUS = mvm_pkg::W_BUS_KX
);

   logic [W_BUS-1:0] m_data;
   logic             m_valid;
   logic             m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver.
//   clk, rst   : system clock, synchronous active-high reset
//   rx         : asynchronous serial input, idles high
//   rx_byte    : last shifted-in byte, LSB received first
//   byte_valid : single-cycle strobe in the cycle a good stop bit is sampled
//   frame_err  : single-cycle pulse, the cycle after a stop bit is sampled low
module uart_rx_byte #(
   parameter int CLOCKS_PER_PULSE = mvm_pkg::CLOCKS_PER_PULSE,
   parameter int BITS_PER_WORD    = mvm_pkg::BITS_PER_WORD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   output logic [BITS_PER_WORD-1:0] rx_byte,
   output logic                     byte_valid,
   output logic                     frame_err
);
   import mvm_pkg::*;

   localparam int CW = $clog2(CLOCKS_PER_PULSE);
   localparam int BW = $clog2(BITS_PER_WORD);

   localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_PULSE/2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_PULSE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_WORD - 1);

   logic [1:0]               sync_q;
   logic                     rx_s;
   rx_state_e                state_q;
   logic [CW-1:0]            cnt_q;
   logic [BW-1:0]            bit_q;
   logic [BITS_PER_WORD-1:0] shift_q;
   logic                     frame_err_q;

   assign rx_s = sync_q[1];

   // NOTE: sequential state is written with <= so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= 2'b11;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], rx};
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q <= START;
                  cnt_q   <= HALF_LOAD;
               end
            end
            START: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (!rx_s) begin
                  state_q <= DATA;
                  cnt_q   <= FULL_LOAD;
                  bit_q   <= '0;
               end else begin
                  // Line went back high before mid start bit: glitch, not a frame.
                  state_q <= IDLE;
               end
            end
            DATA: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  shift_q <= {rx_s, shift_q[BITS_PER_WORD-1:1]};
                  cnt_q   <= FULL_LOAD;
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == LAST_BIT) state_q <= STOP;
               end
            end
            STOP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  // Back to IDLE at mid stop bit so an early next start edge is not missed.
                  frame_err_q <= ~rx_s;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobe is decoded from state so the packer can load its output on the very next edge.
   assign byte_valid = (state_q == STOP) && (cnt_q == '0) && rx_s;
   assign rx_byte    = shift_q;
   assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_rx_packer.sv
// uart_rx_packer: packs N_WORDS consecutive UART bytes into one W_BUS-bit
// operand packet and offers it downstream over a valid/ready handshake.
//   clk, rst  : system clock, synchronous active-high reset
//   rx        : asynchronous serial input, idles high
//   m         : packet bus (m_data / m_valid out, m_ready in)
//   frame_err : one-cycle pulse when a stop bit is sampled low
//   overflow  : one-cycle pulse when a completed packet is dropped because
//               the output register still holds an unaccepted packet
module uart_rx_packer #(
   parameter int CLOCKS_PER_PULSE = mvm_pkg::CLOCKS_PER_PULSE,
   parameter int BITS_PER_WORD    = mvm_pkg::BITS_PER_WORD,
   parameter int W_BUS            = mvm_pkg::W_BUS_KX
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx,
   uart_rx_packer_if.master        m,
   output logic                    frame_err,
   output logic                    overflow
);
   import mvm_pkg::*;

   localparam int N_WORDS = W_BUS / BITS_PER_WORD;
   localparam int IW      = $clog2(N_WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);

   logic [BITS_PER_WORD-1:0] rx_byte;
   logic                     byte_valid;

   logic [IW-1:0]    word_idx_q, word_idx_d;
   logic [W_BUS-1:0] pack_q, pack_d;
   logic [W_BUS-1:0] m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d;
   logic             overflow_q, overflow_d;
   logic [W_BUS-1:0] packet;

   uart_rx_byte #(
      .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
      .BITS_PER_WORD    (BITS_PER_WORD)
   ) u_rx_byte (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   // NOTE: every _d gets a default before any branch, so no path can infer a latch.
   always_comb begin
      word_idx_d = word_idx_q;
      pack_d     = pack_q;
      m_data_d   = m_data_q;
      m_valid_d  = m_valid_q & ~m.m_ready;
      overflow_d = 1'b0;
      packet     = pack_q;

      if (byte_valid) begin
         packet[word_idx_q*BITS_PER_WORD +: BITS_PER_WORD] = rx_byte;
         pack_d = packet;
         if (word_idx_q == LAST_IDX) begin
            word_idx_d = '0;
            // Output register is free if empty or being accepted this very cycle.
            if (!m_valid_q || m.m_ready) begin
               m_data_d  = packet;
               m_valid_d = 1'b1;
            end else begin
               overflow_d = 1'b1;
            end
         end else begin
            word_idx_d = word_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_idx_q <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         word_idx_q <= word_idx_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: the pack register has no reset; word_idx restarts at slot 0, so every
   // slot is rewritten before its contents can ever reach m_data.
   always_ff @(posedge clk) begin
      pack_q <= pack_d;
   end

   assign m.m_data  = m_data_q;
   assign m.m_valid = m_valid_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// tb_uart_rx_packer: self-checking bench for uart_rx_packer.
// Table-driven packet vectors, hand-written handshake/reset sequences, and a
// randomized byte stream checked against a byte-grouping reference model.
module tb_uart_rx_packer;
   import mvm_pkg::*;

   localparam int CPP = 54;

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic frame_err;
   logic overflow;

   uart_rx_packer_if #(.W_BUS(24)) bus ();

   uart_rx_packer dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .m         (bus),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor (samples on falling edge) ----------------
   int          cyc            = 0;
   int          fe_cnt         = 0;
   int          ov_cnt         = 0;
   int          valid_rise_cyc = -1;
   int          stab_viol      = 0;
   logic        prev_valid     = 1'b0;
   logic        prev_held      = 1'b0;
   logic [23:0] prev_data      = '0;
   logic [23:0] acc_q[$];

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (frame_err) fe_cnt++;
         if (overflow)  ov_cnt++;
         if (bus.m_valid && !prev_valid) valid_rise_cyc = cyc;
         if (prev_held && bus.m_data !== prev_data) stab_viol++;
         if (bus.m_valid && bus.m_ready) acc_q.push_back(bus.m_data);
      end
      prev_valid = bus.m_valid;
      prev_held  = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- drivers ----------------
   int last_start_cyc;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      last_start_cyc = cyc;
      rx = 1'b0;
      tick(CPP);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPP);
      end
      rx = stop_bit;
      tick(CPP);
      rx = 1'b1;
      // Let the receiver settle out of the false start caused by a low stop bit.
      if (!stop_bit) tick(60);
   endtask

   task automatic wait_acc(input int n_before);
      for (int i = 0; i < 600 && acc_q.size() <= n_before; i++) tick(1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int               n;
      logic [3:0][7:0]  b;
      logic [3:0]       stop;
      logic             glitch;
      logic [23:0]      exp_data;
      int               exp_fe;
   } vec_t;

   vec_t vecs[3];

   int          meas_lat;
   int          a0, fe0, ov0, lat;
   logic [7:0]  rb;
   logic        good;
   logic [7:0]  pend[$];
   logic [23:0] exp_pk[$];
   int          n_bad;

   initial begin
      vecs[0] = '{3, {8'h00, 8'h0F, 8'h3C, 8'hA5}, 4'b0111, 1'b0, 24'h0F3CA5, 0};
      vecs[1] = '{4, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b1110, 1'b0, 24'h443322, 1};
      vecs[2] = '{3, {8'h00, 8'h03, 8'h02, 8'h01}, 4'b0111, 1'b1, 24'h030201, 0};
      meas_lat = 518;

      // ---- reset state ----
      rst = 1'b1;
      rx  = 1'b1;
      bus.m_ready = 1'b0;
      tick(3);
      check("rst_m_valid",   bus.m_valid, 0);
      check("rst_m_data",    bus.m_data,  0);
      check("rst_frame_err", frame_err,   0);
      check("rst_overflow",  overflow,    0);
      rst = 1'b0;
      tick(5);

      // ---- table-driven packets, m_ready = 1 ----
      bus.m_ready = 1'b1;
      for (int v = 0; v < 3; v++) begin
         a0  = acc_q.size();
         fe0 = fe_cnt;
         ov0 = ov_cnt;
         if (vecs[v].glitch) begin
            rx = 1'b0;
            tick(10);
            rx = 1'b1;
            tick(100);
            check("glitch_no_fe",    fe_cnt - fe0, 0);
            check("glitch_no_valid", bus.m_valid,  0);
         end
         for (int j = 0; j < vecs[v].n; j++) begin
            send_byte(vecs[v].b[j], vecs[v].stop[j]);
            tick($urandom_range(1, 20));
         end
         wait_acc(a0);
         check("vec_pkt_count", acc_q.size() - a0, 1);
         if (acc_q.size() > a0) check("vec_data", acc_q[a0], vecs[v].exp_data);
         lat = valid_rise_cyc - last_start_cyc;
         if (v == 0) meas_lat = lat;
         check("vec_latency_window", (lat >= 505 && lat <= 530), 1);
         check("vec_frame_err", fe_cnt - fe0, vecs[v].exp_fe);
         check("vec_overflow",  ov_cnt - ov0, 0);
         check("vec_valid_dropped", bus.m_valid, 0);
      end

      // ---- backpressure: second packet overflows ----
      bus.m_ready = 1'b0;
      a0  = acc_q.size();
      ov0 = ov_cnt;
      send_byte(8'hAA, 1'b1); tick(5);
      send_byte(8'hBB, 1'b1); tick(5);
      send_byte(8'hCC, 1'b1); tick(5);
      check("bp_valid_held", bus.m_valid, 1);
      check("bp_data_first", bus.m_data, 24'hCCBBAA);
      send_byte(8'h11, 1'b1); tick(5);
      send_byte(8'h22, 1'b1); tick(5);
      send_byte(8'h33, 1'b1); tick(5);
      check("bp_overflow_once", ov_cnt - ov0, 1);
      check("bp_data_kept",     bus.m_data, 24'hCCBBAA);
      bus.m_ready = 1'b1;
      tick(1);
      bus.m_ready = 1'b0;
      tick(2);
      check("bp_accept_count", acc_q.size() - a0, 1);
      if (acc_q.size() > a0) check("bp_accept_data", acc_q[a0], 24'hCCBBAA);
      check("bp_valid_dropped", bus.m_valid, 0);

      // ---- accept and reload on the same edge ----
      a0  = acc_q.size();
      ov0 = ov_cnt;
      send_byte(8'h21, 1'b1); tick(5);
      send_byte(8'h43, 1'b1); tick(5);
      send_byte(8'h65, 1'b1); tick(5);
      check("same_first_held", bus.m_valid, 1);
      send_byte(8'h9A, 1'b1); tick(5);
      send_byte(8'hBC, 1'b1); tick(5);
      // Last byte driven cycle by cycle; m_ready is high only in the cycle
      // whose closing edge loads the new packet.
      for (int c = 0; c < 10*CPP; c++) begin
         if (c < CPP)          rx = 1'b0;
         else if (c < 9*CPP)   rx = rb_bit(8'hDE, (c / CPP) - 1);
         else                  rx = 1'b1;
         bus.m_ready = (c == meas_lat - 2);
         tick(1);
      end
      bus.m_ready = 1'b0;
      tick(2);
      check("same_no_overflow", ov_cnt - ov0, 0);
      check("same_valid_stays", bus.m_valid, 1);
      check("same_new_data",    bus.m_data, 24'hDEBC9A);
      check("same_accept_count", acc_q.size() - a0, 1);
      if (acc_q.size() > a0) check("same_accept_data", acc_q[a0], 24'h654321);
      bus.m_ready = 1'b1;
      tick(2);

      // ---- reset mid-packet and mid-byte ----
      a0 = acc_q.size();
      send_byte(8'h12, 1'b1); tick(5);
      send_byte(8'h34, 1'b1); tick(5);
      rx = 1'b0;
      tick(200);
      rst = 1'b1;
      rx  = 1'b1;
      tick(2);
      check("mid_rst_m_valid",   bus.m_valid, 0);
      check("mid_rst_m_data",    bus.m_data,  0);
      check("mid_rst_frame_err", frame_err,   0);
      check("mid_rst_overflow",  overflow,    0);
      rst = 1'b0;
      tick(5);
      send_byte(8'h55, 1'b1); tick(5);
      send_byte(8'h66, 1'b1); tick(5);
      send_byte(8'h77, 1'b1); tick(5);
      wait_acc(a0);
      check("post_rst_count", acc_q.size() - a0, 1);
      if (acc_q.size() > a0) check("post_rst_data", acc_q[a0], 24'h776655);

      // ---- randomized stream vs. byte-grouping model ----
      a0  = acc_q.size();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      n_bad = 0;
      for (int k = 0; k < 18; k++) begin
         rb   = 8'($urandom);
         good = ($urandom_range(0, 7) != 0);
         send_byte(rb, good);
         if (good) begin
            pend.push_back(rb);
            if (pend.size() == 3) begin
               exp_pk.push_back({pend[2], pend[1], pend[0]});
               pend.delete();
            end
         end else begin
            n_bad++;
         end
         tick($urandom_range(1, 20));
      end
      tick(20);
      check("rand_pkt_count", acc_q.size() - a0, exp_pk.size());
      for (int i = 0; i < exp_pk.size(); i++) begin
         if (a0 + i < acc_q.size()) check("rand_pkt_data", acc_q[a0 + i], exp_pk[i]);
      end
      check("rand_frame_err", fe_cnt - fe0, n_bad);
      check("rand_overflow",  ov_cnt - ov0, 0);

      check("data_stable_while_held", stab_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   function automatic logic rb_bit(input logic [7:0] b, input int i);
      return b[i];
   endfunction

endmodule
